// File: rtl/l1d_sched_pkg.sv
// Shared types and helpers for the L1D data-array port scheduler.
package l1d_sched_pkg;

    localparam int L1D_WIDTH      = 128;
    localparam int L1D_NBYTES     = 16;
    // Buffered store addresses are held at this fixed width and zero-extended
    // from the user module's LG_DEPTH, so one struct type serves every depth.
    localparam int L1D_ADDR_W_MAX = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [L1D_ADDR_W_MAX-1:0] addr;
        logic [L1D_WIDTH-1:0]      data;
        logic [L1D_NBYTES-1:0]     byte_en;
    } st_entry_t;

    // Per-byte select: bytes with mask set come from new_data, the rest from old_data.
    function automatic logic [L1D_WIDTH-1:0] byte_merge(
        input logic [L1D_WIDTH-1:0]  new_data,
        input logic [L1D_WIDTH-1:0]  old_data,
        input logic [L1D_NBYTES-1:0] mask
    );
        logic [L1D_WIDTH-1:0] res;
        for (int b = 0; b < L1D_NBYTES; b++) begin
            res[b*8 +: 8] = mask[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/l1d_data_port_sched_st_buf.sv
// Small in-order store buffer: ring of SB_ENTRIES slots with per-slot valid,
// exposing the head entry and an address-match vector over the valid slots.
module l1d_st_buf
    import l1d_sched_pkg::*;
#(
    parameter int LG_DEPTH   = 6,
    parameter int SB_ENTRIES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  st_entry_t             push_entry,
    input  logic                  pop,
    output st_entry_t             head,
    output logic                  full,
    output logic                  empty,
    input  logic [LG_DEPTH-1:0]   match_addr,
    output logic [SB_ENTRIES-1:0] match_vec
);

    localparam int PW = (SB_ENTRIES > 1) ? $clog2(SB_ENTRIES) : 1;

    st_entry_t             slots [SB_ENTRIES];
    logic [SB_ENTRIES-1:0] valid;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // Occupancy and pointers; a push after a pop of the same slot wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: slots are only read while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    assign head  = slots[rd_ptr];
    assign full  = &valid;
    assign empty = ~|valid;

    // Address hit against every valid slot, including one being popped now.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < SB_ENTRIES; i++) begin
            match_vec[i] = valid[i] && (slots[i].addr == L1D_ADDR_W_MAX'(match_addr));
        end
    end

endmodule

// File: rtl/l1d_data_port_sched.sv
// L1D data-array port scheduler: zero-fills the array after reset, then
// arbitrates the write port between refills and buffered stores, drives the
// read port for loads and forwards same-cycle writes into load responses.
//
// state | meaning
// INIT  | zero-filling entry init_ptr; no traffic admitted
// RUN   | normal operation; fill > store buffer head on the write port
module l1d_data_port_sched
    import l1d_sched_pkg::*;
#(
    parameter int LG_DEPTH   = 6,
    parameter int SB_ENTRIES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  init_done,
    input  logic                  ld_valid,
    input  logic [LG_DEPTH-1:0]   ld_addr,
    output logic                  ld_ready,
    output logic                  ld_rsp_valid,
    output logic [L1D_WIDTH-1:0]  ld_rsp_data,
    input  logic                  st_valid,
    input  logic [LG_DEPTH-1:0]   st_addr,
    input  logic [L1D_WIDTH-1:0]  st_data,
    input  logic [L1D_NBYTES-1:0] st_byte_en,
    output logic                  st_ready,
    input  logic                  fill_valid,
    input  logic [LG_DEPTH-1:0]   fill_addr,
    input  logic [L1D_WIDTH-1:0]  fill_data,
    output logic [LG_DEPTH-1:0]   ram_rd_addr,
    output logic                  ram_wr_en,
    output logic [LG_DEPTH-1:0]   ram_wr_addr,
    output logic [L1D_WIDTH-1:0]  ram_wr_data,
    output logic [L1D_NBYTES-1:0] ram_wr_byte_en,
    input  logic [L1D_WIDTH-1:0]  ram_rd_data
);

    state_t                state;
    state_t                state_nxt;
    logic [LG_DEPTH-1:0]   init_ptr;
    logic                  run;

    logic                  sb_push;
    logic                  sb_pop;
    st_entry_t             sb_push_entry;
    st_entry_t             sb_head;
    logic                  sb_full;
    logic                  sb_empty;
    logic [SB_ENTRIES-1:0] sb_match;

    logic                  ld_accept;
    logic [LG_DEPTH-1:0]   rd_addr_q;
    logic [L1D_WIDTH-1:0]  fwd_data;
    logic [L1D_NBYTES-1:0] fwd_mask;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT once the last entry is being zeroed.
    always_comb begin
        state_nxt = state;
        if (state == INIT && init_ptr == {LG_DEPTH{1'b1}}) begin
            state_nxt = RUN;
        end
    end

    // Zero-fill pointer walks the whole array once per reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_ptr <= '0;
        end else if (state == INIT) begin
            init_ptr <= init_ptr + 1'b1;
        end
    end

    // Write-port outputs: zero-fill in INIT, then fill over store buffer head.
    always_comb begin
        ram_wr_en      = 1'b0;
        ram_wr_addr    = '0;
        ram_wr_data    = '0;
        ram_wr_byte_en = '0;
        sb_pop         = 1'b0;
        unique case (state)
            INIT: begin
                ram_wr_en      = 1'b1;
                ram_wr_addr    = init_ptr;
                ram_wr_byte_en = '1;
            end
            RUN: begin
                if (fill_valid) begin
                    ram_wr_en      = 1'b1;
                    ram_wr_addr    = fill_addr;
                    ram_wr_data    = fill_data;
                    ram_wr_byte_en = '1;
                end else if (!sb_empty) begin
                    ram_wr_en      = 1'b1;
                    ram_wr_addr    = LG_DEPTH'(sb_head.addr);
                    ram_wr_data    = sb_head.data;
                    ram_wr_byte_en = sb_head.byte_en;
                    sb_pop         = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run       = (state == RUN);
    assign init_done = run;
    assign st_ready  = run && !sb_full;
    assign sb_push   = st_valid && st_ready;

    // A load waits while any buffered store targets its index; a store
    // arriving in the same cycle is not yet buffered, so the load sees old data.
    assign ld_ready  = run && !(|sb_match);
    assign ld_accept = ld_valid && ld_ready;

    assign sb_push_entry = '{addr:    L1D_ADDR_W_MAX'(st_addr),
                             data:    st_data,
                             byte_en: st_byte_en};

    l1d_st_buf #(
        .LG_DEPTH   (LG_DEPTH),
        .SB_ENTRIES (SB_ENTRIES)
    ) u_st_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (sb_push),
        .push_entry (sb_push_entry),
        .pop        (sb_pop),
        .head       (sb_head),
        .full       (sb_full),
        .empty      (sb_empty),
        .match_addr (ld_addr),
        .match_vec  (sb_match)
    );

    assign ram_rd_addr = ld_accept ? ld_addr : rd_addr_q;

    // Load response tracking and capture of a colliding same-cycle write,
    // since the array returns pre-write data on a read/write collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q    <= '0;
            ld_rsp_valid <= 1'b0;
            fwd_data     <= '0;
            fwd_mask     <= '0;
        end else begin
            ld_rsp_valid <= ld_accept;
            if (ld_accept) begin
                rd_addr_q <= ld_addr;
                fwd_data  <= ram_wr_data;
                fwd_mask  <= (ram_wr_en && ram_wr_addr == ld_addr) ? ram_wr_byte_en : '0;
            end
        end
    end

    assign ld_rsp_data = byte_merge(fwd_data, ram_rd_data, fwd_mask);

    // Refills are not admitted while the array is being zeroed.
    a_no_fill_in_init : assert property (@(posedge clk) disable iff (!reset_n)
        !(fill_valid && state == INIT));

endmodule

// File: tb/tb_l1d_data_port_sched.sv
// Directed bench for l1d_data_port_sched with a behavioural 1R1W array model.
module tb_l1d_data_port_sched;

    localparam int LGD = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           init_done;
    logic           ld_valid;
    logic [LGD-1:0] ld_addr;
    logic           ld_ready;
    logic           ld_rsp_valid;
    logic [127:0]   ld_rsp_data;
    logic           st_valid;
    logic [LGD-1:0] st_addr;
    logic [127:0]   st_data;
    logic [15:0]    st_byte_en;
    logic           st_ready;
    logic           fill_valid;
    logic [LGD-1:0] fill_addr;
    logic [127:0]   fill_data;
    logic [LGD-1:0] ram_rd_addr;
    logic           ram_wr_en;
    logic [LGD-1:0] ram_wr_addr;
    logic [127:0]   ram_wr_data;
    logic [15:0]    ram_wr_byte_en;
    logic [127:0]   ram_rd_data;

    logic [127:0]   mem [16];
    int             checks = 0;
    int             errors = 0;

    localparam logic [127:0] FILL7 = 128'h0123456789ABCDEF0123456789ABCDEF;

    l1d_data_port_sched #(.LG_DEPTH(LGD), .SB_ENTRIES(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .init_done      (init_done),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_ready       (ld_ready),
        .ld_rsp_valid   (ld_rsp_valid),
        .ld_rsp_data    (ld_rsp_data),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_byte_en     (st_byte_en),
        .st_ready       (st_ready),
        .fill_valid     (fill_valid),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .ram_rd_addr    (ram_rd_addr),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_byte_en (ram_wr_byte_en),
        .ram_rd_data    (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Array model: registered read, returns pre-write data on a collision.
    always @(posedge clk) begin : ram_model
        logic [127:0] w;
        if (ram_wr_en) begin
            w = mem[ram_wr_addr];
            for (int b = 0; b < 16; b++) begin
                if (ram_wr_byte_en[b]) w[b*8 +: 8] = ram_wr_data[b*8 +: 8];
            end
            mem[ram_wr_addr] <= w;
        end
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_valid   = 1'b0;
        ld_addr    = '0;
        st_valid   = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        st_byte_en = '0;
        fill_valid = 1'b0;
        fill_addr  = '0;
        fill_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {8{16'hDEAD}};
        ram_rd_data = '0;
        reset_n = 1'b0;
        idle();

        // ---- reset state ----
        repeat (3) tick();
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_st_ready", st_ready, 0);
        chk("rst_rsp_valid", ld_rsp_valid, 0);
        chk("rst_wr_en", ram_wr_en, 1);
        chk("rst_wr_addr", ram_wr_addr, 0);

        // ---- zero-fill: 16 cycles, addr 0..15, readiness low throughout ----
        reset_n  = 1'b1;
        ld_valid = 1'b1;
        st_valid = 1'b1;
        st_byte_en = 16'hFFFF;
        st_data  = {16{8'h55}};
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_wr_en", ram_wr_en, 1);
            chk("init_wr_addr", ram_wr_addr, i);
            chk("init_wr_data", ram_wr_data, 0);
            chk("init_wr_be", ram_wr_byte_en, 16'hFFFF);
            chk("init_done_low", init_done, 0);
            chk("init_ld_ready", ld_ready, 0);
            chk("init_st_ready", st_ready, 0);
            tick();
        end
        idle();
        #1;
        chk("run_init_done", init_done, 1);
        chk("run_ld_ready", ld_ready, 1);
        chk("run_st_ready", st_ready, 1);
        chk("run_wr_idle", ram_wr_en, 0);
        tick();

        // ---- store addr 3 then load addr 3: held until the store drains ----
        st_valid = 1'b1; st_addr = 3; st_data = 128'hAB; st_byte_en = 16'h0001;
        #1;
        chk("a_st_ready", st_ready, 1);
        tick();
        idle(); ld_valid = 1'b1; ld_addr = 3;
        #1;
        chk("a_ld_blocked", ld_ready, 0);
        chk("a_drain_en", ram_wr_en, 1);
        chk("a_drain_addr", ram_wr_addr, 3);
        chk("a_drain_be", ram_wr_byte_en, 16'h0001);
        chk("a_drain_data", ram_wr_data, 128'hAB);
        tick();
        #1;
        chk("a_ld_ready", ld_ready, 1);
        chk("a_rd_addr", ram_rd_addr, 3);
        chk("a_wr_idle", ram_wr_en, 0);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("a_rsp_valid", ld_rsp_valid, 1);
        chk("a_rsp_data", ld_rsp_data, 128'hAB);
        tick();
        #1;
        chk("a_rsp_one_shot", ld_rsp_valid, 0);
        chk("a_rd_addr_hold", ram_rd_addr, 3);
        tick();

        // ---- fill addr 7 with same-cycle load: forwarded ----
        fill_valid = 1'b1; fill_addr = 7; fill_data = FILL7;
        ld_valid = 1'b1; ld_addr = 7;
        #1;
        chk("b_ld_ready", ld_ready, 1);
        chk("b_wr_addr", ram_wr_addr, 7);
        chk("b_wr_be", ram_wr_byte_en, 16'hFFFF);
        tick();
        idle();
        #1;
        chk("b_rsp_valid", ld_rsp_valid, 1);
        chk("b_rsp_fwd", ld_rsp_data, FILL7);
        tick();

        // ---- fill held 4 cycles while 3 stores are offered ----
        fill_valid = 1'b1; fill_addr = 12; fill_data = {16{8'h5A}};
        st_valid = 1'b1; st_addr = 8; st_data = {16{8'hA1}}; st_byte_en = 16'hFFFF;
        #1;
        chk("c_s1_ready", st_ready, 1);
        chk("c_fill_wins0", ram_wr_addr, 12);
        tick();
        st_addr = 9; st_data = {16{8'hB2}}; st_byte_en = 16'h00FF;
        #1;
        chk("c_s2_ready", st_ready, 1);
        chk("c_fill_wins1", ram_wr_addr, 12);
        tick();
        st_addr = 10; st_data = {16{8'hC3}}; st_byte_en = 16'hF0F0;
        #1;
        chk("c_s3_full0", st_ready, 0);
        tick();
        #1;
        chk("c_s3_full1", st_ready, 0);
        chk("c_fill_wins3", ram_wr_addr, 12);
        tick();
        fill_valid = 1'b0;
        #1;
        chk("c_s3_full2", st_ready, 0);
        chk("c_d0_en", ram_wr_en, 1);
        chk("c_d0_addr", ram_wr_addr, 8);
        chk("c_d0_data", ram_wr_data, {16{8'hA1}});
        chk("c_d0_be", ram_wr_byte_en, 16'hFFFF);
        tick();
        #1;
        chk("c_s3_accept", st_ready, 1);
        chk("c_d1_addr", ram_wr_addr, 9);
        chk("c_d1_be", ram_wr_byte_en, 16'h00FF);
        tick();
        idle();
        #1;
        chk("c_d2_en", ram_wr_en, 1);
        chk("c_d2_addr", ram_wr_addr, 10);
        chk("c_d2_be", ram_wr_byte_en, 16'hF0F0);
        chk("c_d2_data", ram_wr_data, {16{8'hC3}});
        tick();
        ld_valid = 1'b1; ld_addr = 9;
        #1;
        chk("c_drained", ram_wr_en, 0);
        chk("c_ld9_ready", ld_ready, 1);
        tick();
        ld_addr = 10;
        #1;
        chk("c_rsp9", ld_rsp_data, 128'h0000000000000000B2B2B2B2B2B2B2B2);
        tick();
        idle();
        #1;
        chk("c_rsp10_valid", ld_rsp_valid, 1);
        chk("c_rsp10", ld_rsp_data, 128'hC3C3C3C300000000C3C3C3C300000000);
        tick();

        // ---- store addr 5 behind a same-cycle fill of addr 5 ----
        fill_valid = 1'b1; fill_addr = 5; fill_data = {16{8'h11}};
        st_valid = 1'b1; st_addr = 5; st_data = {16{8'h77}}; st_byte_en = 16'hFF00;
        #1;
        chk("d_st_ready", st_ready, 1);
        chk("d_fill_addr", ram_wr_addr, 5);
        tick();
        idle(); ld_valid = 1'b1; ld_addr = 5;
        #1;
        chk("d_ld_blocked", ld_ready, 0);
        chk("d_st_addr", ram_wr_addr, 5);
        chk("d_st_be", ram_wr_byte_en, 16'hFF00);
        tick();
        #1;
        chk("d_ld_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("d_rsp", ld_rsp_data, 128'h77777777777777771111111111111111);
        tick();

        // ---- store enqueued with a same-cycle load: load not blocked, sees old data ----
        ld_valid = 1'b1; ld_addr = 5;
        st_valid = 1'b1; st_addr = 5; st_data = {16{8'h99}}; st_byte_en = 16'hFFFF;
        #1;
        chk("h_ld_ready", ld_ready, 1);
        chk("h_st_ready", st_ready, 1);
        tick();
        idle();
        #1;
        chk("h_rsp_old", ld_rsp_data, 128'h77777777777777771111111111111111);
        chk("h_st_write", ram_wr_data, {16{8'h99}});
        tick();
        ld_valid = 1'b1; ld_addr = 5;
        #1;
        chk("h_ld2_ready", ld_ready, 1);
        tick();
        idle();
        #1;
        chk("h_rsp_new", ld_rsp_data, {16{8'h99}});
        tick();

        // ---- reset while 2 stores are buffered and a response is in flight ----
        fill_valid = 1'b1; fill_addr = 14; fill_data = {16{8'h3C}};
        st_valid = 1'b1; st_addr = 2; st_data = {16{8'hEE}}; st_byte_en = 16'hFFFF;
        #1;
        chk("e_st0_ready", st_ready, 1);
        tick();
        st_addr = 3; st_data = {16{8'hDD}};
        ld_valid = 1'b1; ld_addr = 0;
        #1;
        chk("e_st1_ready", st_ready, 1);
        chk("e_ld_ready", ld_ready, 1);
        tick();
        idle();
        reset_n = 1'b0;
        #1;
        chk("e_rst_done", init_done, 0);
        chk("e_rst_rsp", ld_rsp_valid, 0);
        chk("e_rst_st_ready", st_ready, 0);
        chk("e_rst_wr_addr", ram_wr_addr, 0);
        chk("e_rst_wr_data", ram_wr_data, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("e_init_en", ram_wr_en, 1);
            chk("e_init_addr", ram_wr_addr, i);
            chk("e_init_data", ram_wr_data, 0);
            chk("e_init_done_low", init_done, 0);
            tick();
        end
        #1;
        chk("e_run_done", init_done, 1);
        chk("e_no_stale_store", ram_wr_en, 0);
        chk("e_st_ready", st_ready, 1);
        chk("e_rsp_idle", ld_rsp_valid, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
